// File: rtl/mod_mult_pkg.sv
// Field constants and multiplier state encoding shared by the
// elliptic-curve arithmetic units.
package elliptic_curve_structs;

    localparam int P_WIDTH = 256;

    // secp256k1 prime: 2^256 - 2^32 - 977
    localparam logic [P_WIDTH-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int CNT_W = $clog2(P_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DBL,
        ADD,
        FIN
    } mult_state_t;

endpackage

// File: rtl/mod_add_sub.sv
// Combinational x +/- y mod P for operands already reduced below P.
// op=0 adds, op=1 subtracts.
module mod_add_sub
    import elliptic_curve_structs::*;
(
    input  logic               op,
    input  logic [P_WIDTH-1:0] x,
    input  logic [P_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] r
);

    logic [P_WIDTH:0] s;
    logic [P_WIDTH:0] s_red;
    logic [P_WIDTH:0] d;
    logic [P_WIDTH:0] d_fix;

    assign s     = {1'b0, x} + {1'b0, y};
    assign s_red = s - {1'b0, P};
    assign d     = {1'b0, x} - {1'b0, y};
    assign d_fix = d + {1'b0, P};

    // Borrow out of the subtraction lands in the top bit.
    always_comb begin
        r = '0;
        if (op) begin
            r = d[P_WIDTH] ? d_fix[P_WIDTH-1:0] : d[P_WIDTH-1:0];
        end else begin
            r = (s >= {1'b0, P}) ? s_red[P_WIDTH-1:0] : s[P_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_mult.sv
// Sequential a*b mod P using MSB-first interleaved double-and-add,
// one modular double and one conditional modular add per bit.
module mod_mult
    import elliptic_curve_structs::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] product,
    output logic               Done,
    output logic               Busy
);

    mult_state_t state;
    mult_state_t state_n;

    logic [P_WIDTH-1:0] ra;
    logic [P_WIDTH-1:0] rb;
    logic [P_WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [P_WIDTH-1:0] opy;
    logic [P_WIDTH-1:0] sum;
    logic               accept;

    // The Done cycle still counts as busy, so Start is refused there.
    assign accept = (state == IDLE) && Start && !Done;
    assign Busy   = (state != IDLE) || Done;

    // One shared adder: DBL feeds (acc, acc), ADD feeds (acc, ra).
    assign opy = (state == ADD) ? ra : acc;

    mod_add_sub u_add (
        .op (1'b0),
        .x  (acc),
        .y  (opy),
        .r  (sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = DBL;
            DBL:  state_n = ADD;
            ADD:  state_n = (cnt == '0) ? FIN : DBL;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ra      <= '0;
            rb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= (state == FIN);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ra  <= a;
                        rb  <= b;
                        acc <= '0;
                        cnt <= CNT_W'(P_WIDTH - 1);
                    end
                end
                DBL: acc <= sum;
                ADD: begin
                    if (rb[cnt]) acc <= sum;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIN: product <= acc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult.sv
// Directed checks of mod_mult: latency, field edge cases,
// ignored Start while busy, and mid-operation reset.
module tb_mod_mult;

    localparam logic [255:0] PM =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] PM1 = PM - 256'd1;
    localparam logic [255:0] PM2 = PM - 256'd2;
    localparam logic [255:0] TWO128 = 256'd1 << 128;
    localparam logic [255:0] R256 = 256'h1_000003D1;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] product;
    logic         Done;
    logic         Busy;

    int n_chk;
    int n_err;
    int cyc;
    int t0;

    mod_mult dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .a       (a),
        .b       (b),
        .product (product),
        .Done    (Done),
        .Busy    (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [255:0] x,
                            input logic [255:0] y);
        a     = x;
        b     = y;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 600) begin
            tick();
            lat = cyc - t0;
        end
    endtask

    task automatic run(input string tag,
                       input logic [255:0] x,
                       input logic [255:0] y,
                       input logic [255:0] exp);
        int lat;
        do_start(x, y);
        chk({tag, " busy"}, {255'd0, Busy}, 256'd1);
        wait_done(lat);
        chk({tag, " latency"}, 256'(lat), 256'd513);
        chk({tag, " product"}, product, exp);
        tick();
        chk({tag, " done low"}, {255'd0, Done}, 256'd0);
        chk({tag, " hold"}, product, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        n_chk = 0;
        n_err = 0;
        Reset = 1'b1;
        Start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle product", product, 256'd0);
            chk("idle done", {255'd0, Done}, 256'd0);
            chk("idle busy", {255'd0, Busy}, 256'd0);
        end

        run("3x5", 256'd3, 256'd5, 256'd15);
        run("2^128sq", TWO128, TWO128, R256);
        run("pm1sq", PM1, PM1, 256'd1);
        run("pm1x2", PM1, 256'd2, PM2);
        run("0xpm1", 256'd0, PM1, 256'd0);
        run("pm1x0", PM1, 256'd0, 256'd0);

        // Start pulse mid-operation must be ignored.
        do_start(256'd7, 256'd9);
        while (cyc - t0 < 99) tick();
        a     = 256'd1;
        b     = 256'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(lat);
        chk("ign latency", 256'(lat), 256'd513);
        chk("ign product", product, 256'd63);
        tick();

        // Reset mid-loop discards the operation.
        do_start(256'd11, 256'd13);
        while (cyc - t0 < 199) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst product", product, 256'd0);
        chk("rst done", {255'd0, Done}, 256'd0);
        chk("rst busy", {255'd0, Busy}, 256'd0);
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (Done) pulses++;
        end
        chk("rst no done", 256'(pulses), 256'd0);
        chk("rst idle busy", {255'd0, Busy}, 256'd0);

        run("4x6", 256'd4, 256'd6, 256'd24);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
